// File: rtl/pool_pkg.sv
// pool_pkg: shared state encoding and width helper for the pooling stage.
package pool_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_e;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/slb_axis_cnt.sv
// slb_axis_cnt: one raster axis - index with wrap, stride phase, window alignment and pooled index.
module slb_axis_cnt
  import pool_pkg::*;
#(
  parameter int LEN = 26,
  parameter int POOL_K = 2,
  parameter int STRIDE = 2,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         step,
  output logic [W-1:0] idx,
  output logic [W-1:0] oidx,
  output logic         wrap,
  output logic         aligned
);
  localparam int PW = clog2(STRIDE + 1);
  logic [W-1:0] idx_q, idx_d, o_q, o_d;
  logic [PW-1:0] ph_q, ph_d;
  logic past_k;
  always_comb begin
    past_k = idx_q >= W'(POOL_K - 1);
    wrap = step && idx_q == W'(LEN - 1);
    aligned = past_k && ph_q == '0;
    idx_d = (clr || wrap) ? '0 : step ? idx_q + 1'b1 : idx_q;
    ph_d = (clr || (step && (wrap || !past_k))) ? '0 :
           !step ? ph_q : ph_q == PW'(STRIDE - 1) ? '0 : ph_q + 1'b1;
    // pooled index counts aligned positions already passed on this line/frame
    o_d = (clr || wrap) ? '0 : (step && aligned) ? o_q + 1'b1 : o_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      ph_q <= '0;
      o_q <= '0;
    end else begin
      idx_q <= idx_d;
      ph_q <= ph_d;
      o_q <= o_d;
    end
  end
  assign idx = idx_q;
  assign oidx = o_q;
endmodule

// File: rtl/slb_window_ctrl.sv
// slb_window_ctrl: raster tracking and KxK/stride window sequencing for the pooling line buffer.
module slb_window_ctrl
  import pool_pkg::*;
#(
  parameter int IMG_W = 26,
  parameter int IMG_H = 26,
  parameter int POOL_K = 2,
  parameter int STRIDE = 2,
  localparam int CNT_W = clog2((IMG_W > IMG_H ? IMG_W : IMG_H) + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             pix_valid,
  output logic             busy,
  output logic             line_ready,
  output logic             win_valid,
  output logic [CNT_W-1:0] out_col,
  output logic [CNT_W-1:0] out_row,
  output logic             frame_done
);
  state_e st_q, st_d;
  logic acc, cnt_clr, col_wrap, row_wrap, col_al, row_al, fill_end;
  logic win_d, win_q, fd_d, fd_q;
  logic [CNT_W-1:0] col, row, col_o, row_o, oc_d, oc_q, or_d, or_q;
  assign acc = pix_valid && !clear && st_q != IDLE;
  assign cnt_clr = clear || st_q == IDLE;
  slb_axis_cnt #(.LEN(IMG_W), .POOL_K(POOL_K), .STRIDE(STRIDE), .W(CNT_W)) u_col (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .step(acc),
    .idx(col), .oidx(col_o), .wrap(col_wrap), .aligned(col_al)
  );
  slb_axis_cnt #(.LEN(IMG_H), .POOL_K(POOL_K), .STRIDE(STRIDE), .W(CNT_W)) u_row (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .step(col_wrap),
    .idx(row), .oidx(row_o), .wrap(row_wrap), .aligned(row_al)
  );
  always_comb begin
    win_d = acc && col_al && row_al;
    fd_d = row_wrap;
    // a single-row window never needs a fill phase
    fill_end = POOL_K > 1 && col_wrap && row == CNT_W'(POOL_K > 1 ? POOL_K - 2 : 0);
    st_d = clear ? IDLE :
           (st_q == IDLE && start) ? (POOL_K > 1 ? FILL : RUN) :
           row_wrap ? IDLE :
           (st_q == FILL && fill_end) ? RUN : st_q;
    oc_d = clear ? '0 : win_d ? col_o : oc_q;
    or_d = clear ? '0 : win_d ? row_o : or_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      win_q <= 1'b0;
      fd_q <= 1'b0;
      oc_q <= '0;
      or_q <= '0;
    end else begin
      st_q <= st_d;
      win_q <= win_d;
      fd_q <= fd_d;
      oc_q <= oc_d;
      or_q <= or_d;
    end
  end
  assign busy = st_q != IDLE;
  assign line_ready = st_q == RUN;
  assign win_valid = win_q;
  assign frame_done = fd_q;
  assign out_col = oc_q;
  assign out_row = or_q;
endmodule

// File: tb/tb_slb_window_ctrl.sv
// tb_slb_window_ctrl: directed checks of window sequencing on three parameterisations.
module tb_slb_window_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, pix_valid = 1'b0;
  logic [2:0] start = '0;
  logic [2:0] busy, lr, win, fd;
  logic [4:0] oc0, or0;
  logic [3:0] oc1, or1;
  logic [2:0] oc2, or2;
  int sel = 0;
  logic m_busy, m_lr, m_win, m_fd;
  int m_oc, m_or;
  int checks = 0, errors = 0;
  int n_win, first_win, lr_pix, last_oc, last_or, n_done, done_win, done_busy, done_lr;
  int win_err, coord_err, idle_win;

  always #5 clk = ~clk;

  slb_window_ctrl u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .clear(clear), .pix_valid(pix_valid),
    .busy(busy[0]), .line_ready(lr[0]), .win_valid(win[0]), .out_col(oc0), .out_row(or0),
    .frame_done(fd[0])
  );
  slb_window_ctrl #(.IMG_W(8), .IMG_H(8), .POOL_K(3), .STRIDE(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .clear(clear), .pix_valid(pix_valid),
    .busy(busy[1]), .line_ready(lr[1]), .win_valid(win[1]), .out_col(oc1), .out_row(or1),
    .frame_done(fd[1])
  );
  slb_window_ctrl #(.IMG_W(7), .IMG_H(4), .POOL_K(2), .STRIDE(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .clear(clear), .pix_valid(pix_valid),
    .busy(busy[2]), .line_ready(lr[2]), .win_valid(win[2]), .out_col(oc2), .out_row(or2),
    .frame_done(fd[2])
  );

  always_comb begin
    m_busy = busy[sel];
    m_lr = lr[sel];
    m_win = win[sel];
    m_fd = fd[sel];
    m_oc = sel == 0 ? int'(oc0) : sel == 1 ? int'(oc1) : int'(oc2);
    m_or = sel == 0 ? int'(or0) : sel == 1 ? int'(or1) : int'(or2);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // start (with a same-cycle pixel that must be ignored), then n pixels with gap idle slots each
  task automatic run_frame(input int s, input int w, input int h, input int k, input int st,
                           input int gap, input int restart_at, input int n);
    int r, c, ew, np;
    np = n > 0 ? n : w * h;
    sel = s;
    n_win = 0; first_win = -1; lr_pix = -1; last_oc = -1; last_or = -1; n_done = 0;
    done_win = -1; done_busy = -1; done_lr = -1; win_err = 0; coord_err = 0; idle_win = 0;
    start[s] = 1'b1;
    pix_valid = 1'b1;
    @(posedge clk);
    #1;
    start[s] = 1'b0;
    pix_valid = 1'b0;
    check("busy_after_start", int'(m_busy), 1);
    for (int p = 0; p < np; p++) begin
      repeat (gap) begin
        @(posedge clk);
        #1;
        if (m_win) idle_win++;
      end
      pix_valid = 1'b1;
      if (p == restart_at) start[s] = 1'b1;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      start[s] = 1'b0;
      r = p / w;
      c = p % w;
      ew = (r >= k - 1 && c >= k - 1 && (r - k + 1) % st == 0 && (c - k + 1) % st == 0) ? 1 : 0;
      if (int'(m_win) != ew) win_err++;
      if (m_win) begin
        n_win++;
        if (first_win < 0) first_win = p + 1;
        if (m_oc != (c - k + 1) / st || m_or != (r - k + 1) / st) coord_err++;
        last_oc = m_oc;
        last_or = m_or;
      end
      if (m_lr && lr_pix < 0) lr_pix = p + 1;
      if (m_fd) begin
        n_done++;
        done_win = int'(m_win);
        done_busy = int'(m_busy);
        done_lr = int'(m_lr);
      end
    end
  endtask

  task automatic verify(input string t, input int e_win, input int e_first, input int e_lr,
                        input int e_oc, input int e_or, input int e_dwin);
    check({t, "_nwin"}, n_win, e_win);
    check({t, "_first_win"}, first_win, e_first);
    check({t, "_line_ready_pix"}, lr_pix, e_lr);
    check({t, "_last_col"}, last_oc, e_oc);
    check({t, "_last_row"}, last_or, e_or);
    check({t, "_ndone"}, n_done, 1);
    check({t, "_done_win"}, done_win, e_dwin);
    check({t, "_done_busy"}, done_busy, 0);
    check({t, "_done_lr"}, done_lr, 0);
    check({t, "_win_pattern"}, win_err, 0);
    check({t, "_coords"}, coord_err, 0);
  endtask

  task automatic check_zero(input string t);
    check({t, "_busy"}, int'(m_busy), 0);
    check({t, "_lr"}, int'(m_lr), 0);
    check({t, "_win"}, int'(m_win), 0);
    check({t, "_fd"}, int'(m_fd), 0);
    check({t, "_oc"}, m_oc, 0);
    check({t, "_or"}, m_or, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    // async reset mid-frame with a window just flagged
    run_frame(0, 26, 26, 2, 2, 0, -1, 30);
    check("pre_rst_win", int'(m_win), 1);
    check("pre_rst_oc", m_oc, 1);
    check("pre_rst_lr", int'(m_lr), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    #1;
    rst_n = 1'b1;
    pix_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pix_valid = 1'b0;
    check_zero("no_start");
    // full default frame, back-to-back
    run_frame(0, 26, 26, 2, 2, 0, -1, 0);
    verify("dflt", 169, 28, 26, 12, 12, 1);
    // same frame with two idle slots per pixel
    run_frame(0, 26, 26, 2, 2, 2, -1, 0);
    verify("gap", 169, 28, 26, 12, 12, 1);
    check("gap_idle_win", idle_win, 0);
    // clear at pixel 100 with competing start and pixel
    run_frame(0, 26, 26, 2, 2, 0, -1, 100);
    clear = 1'b1;
    start[0] = 1'b1;
    pix_valid = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    start[0] = 1'b0;
    pix_valid = 1'b0;
    check_zero("clear");
    run_frame(0, 26, 26, 2, 2, 0, -1, 0);
    verify("after_clr", 169, 28, 26, 12, 12, 1);
    // start pulse mid-frame is ignored
    run_frame(0, 26, 26, 2, 2, 0, 50, 0);
    verify("restart", 169, 28, 26, 12, 12, 1);
    // 8x8, K=3, S=1
    run_frame(1, 8, 8, 3, 1, 0, -1, 0);
    verify("k3s1", 36, 19, 16, 5, 5, 1);
    // 7x4, K=2, S=2: trailing column 6 never flagged
    run_frame(2, 7, 4, 2, 2, 0, -1, 0);
    verify("w7", 6, 9, 7, 2, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
